cla_pipe_adder: RTL and testbench

- Two-stage pipelined carry-lookahead adder. It is the consumer side of the per-bit propagate/generate interface.
- Stage 1 forms and registers per-bit p = a^b and g = a&b together with carry-in.
- Stage 2 resolves group carries with lookahead logic, then registers sum, carry-out and overflow.
- Valid/ready streaming handshake on both sides. Sits in the datapath wherever multi-operand traffic needs a registered adder with backpressure.

---
 rtl/cla_pipe_adder.sv | 129 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Stage 1 registers per-bit propagate/generate; stage 2 resolves carries and registers the result.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGRP = WIDTH / GROUP;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] g_reg;
  logic             c0_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic             adv1;
  logic             adv2;

  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;

  // Ready chain: a stage may load whenever the stage after it can move on.
  assign adv2     = !out_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  genvar gi;
  generate
    for (gi = 0; gi < NGRP; gi++) begin : g_grp
      logic [GROUP-1:0] gp;
      logic [GROUP-1:0] gg;
      logic             blk_g;

      assign gp = p_reg[gi*GROUP +: GROUP];
      assign gg = g_reg[gi*GROUP +: GROUP];

      // Group generate: carry out of the group assuming no carry in.
      always_comb begin
        blk_g = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
          blk_g = gg[i] | (gp[i] & blk_g);
        end
      end

      assign grp_g[gi] = blk_g;
      assign grp_p[gi] = &gp;
    end
  endgenerate

  // Group carries ripple between groups; bit carries are resolved inside each group.
  always_comb begin : carry_chain
    logic [WIDTH:0] c;
    logic           grp_c;
    c     = '0;
    grp_c = c0_reg;
    for (int k = 0; k < NGRP; k++) begin
      c[k*GROUP] = grp_c;
      for (int i = 0; i < GROUP - 1; i++) begin
        c[k*GROUP+i+1] = g_reg[k*GROUP+i] | (p_reg[k*GROUP+i] & c[k*GROUP+i]);
      end
      grp_c = grp_g[k] | (grp_p[k] & grp_c);
    end
    c[WIDTH] = grp_c;
    carry    = c;
  end

  assign sum_next  = p_reg ^ carry[WIDTH-1:0];
  assign cout_next = carry[WIDTH];
  assign ovf_next  = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      p_reg        <= '0;
      g_reg        <= '0;
      c0_reg       <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        p_reg  <= a ^ b;
        g_reg  <= a & b;
        c0_reg <= cin;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if (adv2) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg  <= sum_next;
        cout_reg <= cout_next;
        ovf_reg  <= ovf_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed vector table, random streaming
// against an arithmetic reference, backpressure and mid-stream reset sequences.
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } res_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   first_acc = -1;
  int   first_out = -1;
  res_t exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic res_t ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
    logic [WIDTH:0] t;
    res_t r;
    t    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.s  = t[WIDTH-1:0];
    r.co = t[WIDTH];
    r.ov = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: expected results queued at accept, compared at the output handshake.
  initial begin : scoreboard
    logic             prev_stall;
    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;
    logic             prev_ovf;
    res_t             e;
    prev_stall = 1'b0;
    prev_sum   = '0;
    prev_cout  = 1'b0;
    prev_ovf   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_sum", sum, prev_sum);
          check("hold_cout", cout, prev_cout);
          check("hold_ovf", ovf, prev_ovf);
        end
        check("in_ready_rule", in_ready, (exp_q.size() < 2) || out_ready);
        if (out_valid && out_ready) begin
          if (first_out < 0) first_out = cyc;
          if (exp_q.size() == 0) begin
            check("spurious_out", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_sum", sum, e.s);
            check("sb_cout", cout, e.co);
            check("sb_ovf", ovf, e.ov);
          end
        end
        if (in_valid && in_ready) begin
          if (first_acc < 0) first_acc = cyc;
          exp_q.push_back(ref_add(a, b, cin));
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Single beat into an empty pipe: result visible 2 cycles later for exactly one cycle.
  task automatic apply_vec(input vec_t v);
    a = v.a; b = v.b; cin = v.cin;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({v.name, "_accept"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    @(negedge clk);
    check({v.name, "_early"}, out_valid, 0);
    step();
    @(negedge clk);
    check({v.name, "_valid"}, out_valid, 1);
    check({v.name, "_sum"}, sum, v.s);
    check({v.name, "_cout"}, cout, v.co);
    check({v.name, "_ovf"}, ovf, v.ov);
    step();
    @(negedge clk);
    check({v.name, "_oneshot"}, out_valid, 0);
    step();
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int accepts;
    vecs[0] = '{"basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"fullcy",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"posovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{"mixsign",  16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{"alt",      16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #2 reset = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // Back-to-back streaming with no backpressure.
    first_acc = -1;
    first_out = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      check("stream_ready", in_ready, 1);
      step();
    end
    drain("stream_drain");
    check("stream_latency", first_out - first_acc, 2);

    // Output stalled from an empty pipe: exactly two beats fit before in_ready drops.
    out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) accepts++;
      step();
    end
    check("bp_accepts", accepts, 2);
    drain("bp_drain");

    // Random valid/ready traffic.
    for (int i = 0; i < 300; i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain("rand_drain");

    // Fill both stages, then reset mid-stream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h0101; b = 16'h0202; cin = 1'b0;
    step();
    a = 16'h0303; b = 16'h0404;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("prerst_full", out_valid, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_sum", sum, 0);
    check("async_cout", cout, 0);
    check("async_ovf", ovf, 0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
      step();
    end
    apply_vec(vecs[0]);
    drain("final_drain");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
